score_board: RTL and testbench
==============================

SCORE_BOARD -- requirements
Module: score_board

Interface
REQ-001 WIDTH, default 32: width of a bus word; bits [WIDTH-1:WIDTH-8] are the destination ID and the rest is payload.
REQ-002 TS_W, default 32: timestamp and latency width.
REQ-003 PROFUNDIDAD, default 16: number of pending-transaction entries.
REQ-004 DRIVERS, default 2: number of bus endpoints.
REQ-005 BROADCAST, default 8'hFF: destination ID that means broadcast.
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clk_i  in  1  clock.
REQ-008 rst_ni  in  1  asynchronous active-low reset.
REQ-009 in_valid_i  in  1  the agent sent a word this cycle.
REQ-010 in_data_i  in  WIDTH  word sent.
REQ-011 in_time_i  in  TS_W  send timestamp.
REQ-012 req_valid_i  in  1  the checker requests a lookup.
REQ-013 req_data_i  in  WIDTH  word received by the monitor.
REQ-014 rsp_valid_o  out  1  one-cycle lookup response strobe.
REQ-015 rsp_hit_o  out  1  a matching entry was found.
REQ-016 rsp_data_o  out  WIDTH  matched word (0 on miss).
REQ-017 rsp_time_o  out  TS_W  send timestamp of the match (0 on miss).
REQ-018 ver_valid_i  in  1  the checker delivers a verified record.
REQ-019 ver_latencia_i  in  TS_W  latency of the verified record.
REQ-020 report_i  in  1  report command pulse.
REQ-021 rep_valid_o  out  1  one-cycle report strobe.
REQ-022 rep_count_o  out  32  number of verified records.
REQ-023 rep_lat_sum_o  out  TS_W+16  accumulated latency.
REQ-024 rep_lat_min_o / rep_lat_max_o  out  TS_W  minimum and maximum latency.
REQ-025 rep_pending_o  out  $clog2(PROFUNDIDAD)+1  number of occupied entries.
REQ-026 rep_dropped_o  out  16  number of sends dropped because the table was full.

Function
REQ-027 Storage SHALL be a table of PROFUNDIDAD entries, each holding {valid, data, time, remaining-match count}.
REQ-028 When in_valid_i is high, the word SHALL be written into the lowest-index free entry at the clock edge.
- Remaining-match count: DRIVERS-1 for a broadcast destination, 1 otherwise.
REQ-029 If the table is full when in_valid_i is high, the word SHALL be discarded and rep_dropped_o incremented, saturating at 16'hFFFF.
REQ-030 A lookup SHALL respond one cycle after req_valid_i, searching for an exact WIDTH-bit equality among valid entries.
- If several entries match, the oldest one wins (lowest send timestamp; lowest index on a tie).
REQ-031 On a hit, the response SHALL present the entry's data and time, and the entry's remaining count SHALL be decremented.
- The entry is freed when its count reaches 0.
REQ-032 On a miss, the response SHALL drive rsp_hit_o=0 with zero data and time; the table is unchanged.
REQ-033 If an insert and a lookup occur in the same cycle, the lookup SHALL search the pre-edge table.
- The insert SHALL not reuse an entry freed in that same cycle.
REQ-034 On ver_valid_i, the block SHALL add 1 to the count and the latency to the sum, and update min and max.
- Min starts at all-ones and max at 0.
- Count and sum saturate.
REQ-035 Verified inputs arriving in the same cycle as report_i SHALL be included in that report.
REQ-036 A report_i pulse SHALL give rep_valid_o=1 for exactly one cycle, on the next cycle.
- Values are held until the next report.
- Reporting SHALL not clear any statistics.
REQ-037 Every handshake is a single-cycle valid with no ready or backpressure; back-to-back requests on consecutive cycles SHALL each get a response.

Reset
REQ-038 On rst_ni low, the block SHALL asynchronously clear the following:
- all entry valid bits;
- all counters, sum and max;
- rsp_* and rep_* outputs (to 0);
- min (to all-ones).
REQ-039 A reset in the middle of operation SHALL abort any pending response; no strobe is emitted for a request captured before the reset.

Structure
REQ-040 The entry record type, the stats record type and the BROADCAST default SHALL live in the shared package sb_pkg.
REQ-041 One sub-module, sb_match, SHALL hold the combinational oldest-match search and free-slot priority encoder.
- The rest stays in score_board.

Verification
REQ-042 Case 1, two sends and a lookup:
- Stimulus: send 32'h02000001 at t=50 and 32'h02000002 at t=150, then look up 32'h02000001.
- Required response: hit, data 32'h02000001, time 50, and a later report shows pending=1.
REQ-043 Case 2, statistics:
- Stimulus: verified latencies 3 then 4, then report_i.
- Required response: count=2, sum=7, min=3, max=4, pending unchanged.
REQ-044 Case 3, miss:
- Stimulus: look up 32'h02000003.
- Required response: rsp_hit_o=0 with zero data and time, and the table is unchanged.
REQ-045 Case 4, broadcast with DRIVERS=2:
- Stimulus: send 32'hFF0000AA.
- Required response: one lookup hits and frees the entry, and a second lookup misses.
REQ-046 Case 5, full table:
- Stimulus: 17 sends into a 16-entry table.
- Required response: pending=16 and dropped=1.
- Then assert rst_ni low mid-stream: all rep_* values read 0 (min all-ones), and the next send lands in entry 0.

Source files
------------

// File: rtl/sb_pkg.sv
// Shared types for the score_board slice: table entry record, statistics record, broadcast ID.
// Widths here must agree with the score_board WIDTH/TS_W parameters.
package sb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned TIME_W = 32;
  localparam int unsigned RCNT_W = 8;
  localparam logic [7:0] BROADCAST_ID = 8'hFF;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [TIME_W-1:0] ts;
    logic [RCNT_W-1:0] rcnt;
  } entry_t;

  typedef struct packed {
    logic [31:0]        count;
    logic [TIME_W+15:0] lat_sum;
    logic [TIME_W-1:0]  lat_min;
    logic [TIME_W-1:0]  lat_max;
    logic [15:0]        dropped;
  } stats_t;

endpackage

// File: rtl/sb_match.sv
// Combinational oldest-match search plus lowest-free-slot encoder over the pending table.
// Zero latency; no flow control.
module sb_match
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  entry_t [DEPTH-1:0]         tbl,
  input  logic [DATA_W-1:0]          key,
  output logic                       hit,
  output logic [$clog2(DEPTH)-1:0]   hit_idx,
  output logic                       free_vld,
  output logic [$clog2(DEPTH)-1:0]   free_idx
);

  localparam int unsigned IW = $clog2(DEPTH);

  logic [TIME_W-1:0] best_ts;

  // Strict less-than keeps the lowest index when timestamps tie.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    best_ts = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tbl[i].valid && (tbl[i].data == key) && (!hit || (tbl[i].ts < best_ts))) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
        best_ts = tbl[i].ts;
      end
    end
  end

  always_comb begin
    free_vld = 1'b0;
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!tbl[i].valid) begin
        free_vld = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/score_board.sv
// Pending-transaction scoreboard: stores sent words, answers lookups, accumulates latency stats.
// Lookup and report respond one cycle later; no backpressure, full-table sends are dropped and counted.
module score_board
  import sb_pkg::*;
#(
  parameter int unsigned WIDTH       = DATA_W,
  parameter int unsigned TS_W        = TIME_W,
  parameter int unsigned PROFUNDIDAD = 16,
  parameter int unsigned DRIVERS     = 2,
  parameter logic [7:0]  BROADCAST   = BROADCAST_ID
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            in_valid_i,
  input  logic [WIDTH-1:0]                in_data_i,
  input  logic [TS_W-1:0]                 in_time_i,
  input  logic                            req_valid_i,
  input  logic [WIDTH-1:0]                req_data_i,
  output logic                            rsp_valid_o,
  output logic                            rsp_hit_o,
  output logic [WIDTH-1:0]                rsp_data_o,
  output logic [TS_W-1:0]                 rsp_time_o,
  input  logic                            ver_valid_i,
  input  logic [TS_W-1:0]                 ver_latencia_i,
  input  logic                            report_i,
  output logic                            rep_valid_o,
  output logic [31:0]                     rep_count_o,
  output logic [TS_W+15:0]                rep_lat_sum_o,
  output logic [TS_W-1:0]                 rep_lat_min_o,
  output logic [TS_W-1:0]                 rep_lat_max_o,
  output logic [$clog2(PROFUNDIDAD):0]    rep_pending_o,
  output logic [15:0]                     rep_dropped_o
);

  localparam int unsigned IW = $clog2(PROFUNDIDAD);
  localparam int unsigned PW = IW + 1;
  localparam logic [RCNT_W-1:0] BC_CNT = (DRIVERS > 1) ? RCNT_W'(DRIVERS - 1) : RCNT_W'(1);

  entry_t [PROFUNDIDAD-1:0] tbl_q, tbl_nxt;
  stats_t                   st_q, st_nxt;
  logic                     hit, free_vld;
  logic [IW-1:0]            hit_idx, free_idx;
  logic [PW-1:0]            pending_nxt;
  logic [TS_W+16:0]         sum_ext;
  logic                     is_bc;

  sb_match #(.DEPTH(PROFUNDIDAD)) u_match (
    .tbl      (tbl_q),
    .key      (req_data_i),
    .hit      (hit),
    .hit_idx  (hit_idx),
    .free_vld (free_vld),
    .free_idx (free_idx)
  );

  assign is_bc = (in_data_i[WIDTH-1 -: 8] == BROADCAST);

  // Both search and free-slot pick use the pre-edge table, so a slot freed
  // by this cycle's lookup is never the insert target.
  always_comb begin
    tbl_nxt = tbl_q;
    if (req_valid_i && hit) begin
      if (tbl_q[hit_idx].rcnt <= RCNT_W'(1)) begin
        tbl_nxt[hit_idx].valid = 1'b0;
        tbl_nxt[hit_idx].rcnt  = '0;
      end else begin
        tbl_nxt[hit_idx].rcnt = tbl_q[hit_idx].rcnt - RCNT_W'(1);
      end
    end
    if (in_valid_i && free_vld) begin
      tbl_nxt[free_idx] = '{valid: 1'b1, data: in_data_i, ts: in_time_i,
                            rcnt: (is_bc ? BC_CNT : RCNT_W'(1))};
    end
  end

  always_comb begin
    pending_nxt = '0;
    for (int i = 0; i < PROFUNDIDAD; i++) begin
      pending_nxt = pending_nxt + PW'(tbl_nxt[i].valid);
    end
  end

  always_comb begin
    st_nxt  = st_q;
    sum_ext = {1'b0, st_q.lat_sum} + {17'd0, ver_latencia_i};
    if (ver_valid_i) begin
      if (st_q.count != '1) st_nxt.count = st_q.count + 32'd1;
      st_nxt.lat_sum = sum_ext[TS_W+16] ? '1 : sum_ext[TS_W+15:0];
      if (ver_latencia_i < st_q.lat_min) st_nxt.lat_min = ver_latencia_i;
      if (ver_latencia_i > st_q.lat_max) st_nxt.lat_max = ver_latencia_i;
    end
    if (in_valid_i && !free_vld && (st_q.dropped != 16'hFFFF)) begin
      st_nxt.dropped = st_q.dropped + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tbl_q         <= '0;
      st_q          <= '{count: '0, lat_sum: '0, lat_min: '1, lat_max: '0, dropped: '0};
      rsp_valid_o   <= 1'b0;
      rsp_hit_o     <= 1'b0;
      rsp_data_o    <= '0;
      rsp_time_o    <= '0;
      rep_valid_o   <= 1'b0;
      rep_count_o   <= '0;
      rep_lat_sum_o <= '0;
      rep_lat_min_o <= '1;
      rep_lat_max_o <= '0;
      rep_pending_o <= '0;
      rep_dropped_o <= '0;
    end else begin
      tbl_q       <= tbl_nxt;
      st_q        <= st_nxt;
      rsp_valid_o <= req_valid_i;
      rsp_hit_o   <= req_valid_i && hit;
      rsp_data_o  <= (req_valid_i && hit) ? tbl_q[hit_idx].data : '0;
      rsp_time_o  <= (req_valid_i && hit) ? tbl_q[hit_idx].ts : '0;
      rep_valid_o <= report_i;
      if (report_i) begin
        rep_count_o   <= st_nxt.count;
        rep_lat_sum_o <= st_nxt.lat_sum;
        rep_lat_min_o <= st_nxt.lat_min;
        rep_lat_max_o <= st_nxt.lat_max;
        rep_pending_o <= pending_nxt;
        rep_dropped_o <= st_nxt.dropped;
      end
    end
  end

endmodule

// File: tb/tb_score_board.sv
// Scoreboard-driven bench for score_board: expected lookup responses queued at drive time, popped on rsp strobe.
module tb_score_board;
  import sb_pkg::*;

  localparam int W = 32;
  localparam int TW = 32;
  localparam int D = 16;
  localparam int DRV = 2;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            in_valid_i = 1'b0;
  logic [W-1:0]    in_data_i = '0;
  logic [TW-1:0]   in_time_i = '0;
  logic            req_valid_i = 1'b0;
  logic [W-1:0]    req_data_i = '0;
  logic            rsp_valid_o, rsp_hit_o;
  logic [W-1:0]    rsp_data_o;
  logic [TW-1:0]   rsp_time_o;
  logic            ver_valid_i = 1'b0;
  logic [TW-1:0]   ver_latencia_i = '0;
  logic            report_i = 1'b0;
  logic            rep_valid_o;
  logic [31:0]     rep_count_o;
  logic [TW+15:0]  rep_lat_sum_o;
  logic [TW-1:0]   rep_lat_min_o, rep_lat_max_o;
  logic [4:0]      rep_pending_o;
  logic [15:0]     rep_dropped_o;

  always #5 clk_i = ~clk_i;

  score_board dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_time_i(in_time_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_hit_o(rsp_hit_o), .rsp_data_o(rsp_data_o), .rsp_time_o(rsp_time_o),
    .ver_valid_i(ver_valid_i), .ver_latencia_i(ver_latencia_i), .report_i(report_i),
    .rep_valid_o(rep_valid_o), .rep_count_o(rep_count_o), .rep_lat_sum_o(rep_lat_sum_o),
    .rep_lat_min_o(rep_lat_min_o), .rep_lat_max_o(rep_lat_max_o),
    .rep_pending_o(rep_pending_o), .rep_dropped_o(rep_dropped_o)
  );

  typedef struct packed {
    logic          hit;
    logic [W-1:0]  data;
    logic [TW-1:0] ts;
  } rsp_t;

  int   tests = 0;
  int   fails = 0;
  rsp_t exp_q[$];
  rsp_t got_q[$];

  always @(negedge clk_i) begin
    if (rst_ni && rsp_valid_o) got_q.push_back('{rsp_hit_o, rsp_data_o, rsp_time_o});
  end

  // Reference model of the pending table, written from the behavioural rules.
  logic          m_vld[D];
  logic [W-1:0]  m_data[D];
  logic [TW-1:0] m_ts[D];
  int            m_cnt[D];

  function automatic int m_pending();
    int n = 0;
    for (int i = 0; i < D; i++) if (m_vld[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_vld[i] = 1'b0; m_data[i] = '0; m_ts[i] = '0; m_cnt[i] = 0;
    end
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic model_send(input logic [W-1:0] d, input logic [TW-1:0] t);
    int f = -1;
    for (int i = 0; i < D; i++) if (!m_vld[i] && f < 0) f = i;
    if (f >= 0) begin
      m_vld[f] = 1'b1; m_data[f] = d; m_ts[f] = t;
      m_cnt[f] = (d[31:24] == 8'hFF) ? DRV - 1 : 1;
    end
  endtask

  task automatic model_lookup(input logic [W-1:0] d, output rsp_t r);
    int b = -1;
    for (int i = 0; i < D; i++)
      if (m_vld[i] && m_data[i] == d && (b < 0 || m_ts[i] < m_ts[b])) b = i;
    if (b < 0) r = '0;
    else begin
      r = '{1'b1, m_data[b], m_ts[b]};
      m_cnt[b]--;
      if (m_cnt[b] == 0) m_vld[b] = 1'b0;
    end
  endtask

  task automatic drive(input bit iv, input logic [W-1:0] idat, input logic [TW-1:0] it,
                       input bit rv, input logic [W-1:0] rdat,
                       input bit vv, input logic [TW-1:0] lat, input bit rep);
    rsp_t e;
    if (rv) begin model_lookup(rdat, e); exp_q.push_back(e); end
    if (iv) model_send(idat, it);
    in_valid_i = iv; in_data_i = idat; in_time_i = it;
    req_valid_i = rv; req_data_i = rdat;
    ver_valid_i = vv; ver_latencia_i = lat; report_i = rep;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0; req_valid_i = 1'b0; ver_valid_i = 1'b0; report_i = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] d, input logic [TW-1:0] t);
    drive(1'b1, d, t, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic lookup(input logic [W-1:0] d);
    drive(1'b0, '0, '0, 1'b1, d, 1'b0, '0, 1'b0);
  endtask

  task automatic report();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0, 1'b1);
  endtask

  task automatic wait_rsp();
    for (int k = 0; k < 20 && got_q.size() < exp_q.size(); k++) @(negedge clk_i);
  endtask

  task automatic test_reset();
    tests++;
    if (rsp_valid_o !== 1'b0 || rep_valid_o !== 1'b0) begin
      fails++; $display("FAIL reset_strobes: rsp_valid=%b rep_valid=%b required 0/0", rsp_valid_o, rep_valid_o);
    end
    tests++;
    if (rep_count_o !== '0 || rep_lat_sum_o !== '0 || rep_lat_max_o !== '0) begin
      fails++; $display("FAIL reset_stats: count=%0d sum=%0d max=%0d required 0", rep_count_o, rep_lat_sum_o, rep_lat_max_o);
    end
    tests++;
    if (rep_lat_min_o !== '1) begin
      fails++; $display("FAIL reset_min: got %h required ffffffff", rep_lat_min_o);
    end
    tests++;
    if (rep_pending_o !== '0 || rep_dropped_o !== '0 || rsp_data_o !== '0) begin
      fails++; $display("FAIL reset_misc: pending=%0d dropped=%0d rsp_data=%h required 0", rep_pending_o, rep_dropped_o, rsp_data_o);
    end
  endtask

  task automatic test_send_lookup();
    rsp_t g, e;
    send(32'h02000001, 32'd50);
    send(32'h02000002, 32'd150);
    lookup(32'h02000001);
    wait_rsp();
    tests++;
    if (got_q.size() == 0) begin
      fails++; $display("FAIL case1_rsp: no response within budget");
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e || g !== rsp_t'({1'b1, 32'h02000001, 32'd50})) begin
        fails++; $display("FAIL case1_rsp: got %h required %h", g, e);
      end
    end
    report();
    tests++;
    if (rep_valid_o !== 1'b1 || rep_pending_o !== 5'(m_pending())) begin
      fails++; $display("FAIL case1_report: valid=%b pending=%0d required 1/%0d", rep_valid_o, rep_pending_o, m_pending());
    end
    @(posedge clk_i); #1;
    tests++;
    if (rep_valid_o !== 1'b0 || rep_pending_o !== 5'd1) begin
      fails++; $display("FAIL report_one_cycle: valid=%b pending=%0d required 0/1", rep_valid_o, rep_pending_o);
    end
  endtask

  task automatic test_stats();
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'd3, 1'b0);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'd4, 1'b1);
    tests++;
    if (rep_valid_o !== 1'b1 || rep_count_o !== 32'd2 || rep_lat_sum_o !== 48'd7) begin
      fails++; $display("FAIL case2_count_sum: valid=%b count=%0d sum=%0d required 1/2/7", rep_valid_o, rep_count_o, rep_lat_sum_o);
    end
    tests++;
    if (rep_lat_min_o !== 32'd3 || rep_lat_max_o !== 32'd4 || rep_pending_o !== 5'd1) begin
      fails++; $display("FAIL case2_min_max: min=%0d max=%0d pending=%0d required 3/4/1", rep_lat_min_o, rep_lat_max_o, rep_pending_o);
    end
  endtask

  task automatic test_miss();
    rsp_t g, e;
    lookup(32'h02000003);
    wait_rsp();
    tests++;
    if (got_q.size() == 0) begin
      fails++; $display("FAIL case3_miss: no response within budget");
    end else begin
      g = got_q.pop_front(); e = exp_q.pop_front();
      if (g !== e || g !== '0) begin
        fails++; $display("FAIL case3_miss: got %h required %h", g, e);
      end
    end
    report();
    tests++;
    if (rep_pending_o !== 5'd1 || rep_count_o !== 32'd2) begin
      fails++; $display("FAIL case3_unchanged: pending=%0d count=%0d required 1/2", rep_pending_o, rep_count_o);
    end
  endtask

  task automatic test_broadcast();
    rsp_t g, e;
    send(32'hFF0000AA, 32'd400);
    lookup(32'hFF0000AA);
    lookup(32'hFF0000AA);
    wait_rsp();
    for (int n = 0; n < 2; n++) begin
      tests++;
      if (got_q.size() == 0) begin
        fails++; $display("FAIL case4_bcast_%0d: no response within budget", n);
      end else begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        if (g !== e || g.hit !== (n == 0)) begin
          fails++; $display("FAIL case4_bcast_%0d: got %h required %h", n, g, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    rsp_t g, e;
    send(32'h0300000C, 32'd300);
    send(32'h0300000C, 32'd200);
    lookup(32'h0300000C);
    drive(1'b1, 32'h0400000D, 32'd500, 1'b1, 32'h0300000C, 1'b0, '0, 1'b0);
    drive(1'b1, 32'h0400000E, 32'd600, 1'b1, 32'h0400000E, 1'b0, '0, 1'b0);
    lookup(32'h0400000E);
    lookup(32'h0400000D);
    wait_rsp();
    for (int n = 0; n < 5; n++) begin
      tests++;
      if (got_q.size() == 0) begin
        fails++; $display("FAIL b2b_rsp_%0d: no response within budget", n);
      end else begin
        g = got_q.pop_front(); e = exp_q.pop_front();
        if (g !== e) begin
          fails++; $display("FAIL b2b_rsp_%0d: got %h required %h", n, g, e);
        end
      end
    end
  endtask

  task automatic test_full_and_reset();
    rst_ni = 1'b0; model_reset();
    @(posedge clk_i); #1; rst_ni = 1'b1;
    for (int i = 0; i < 17; i++) send(32'h05000000 + 32'(i), 32'(1000 + i));
    report();
    tests++;
    if (rep_pending_o !== 5'd16 || rep_dropped_o !== 16'd1) begin
      fails++; $display("FAIL case5_full: pending=%0d dropped=%0d required 16/1", rep_pending_o, rep_dropped_o);
    end
    drive(1'b0, '0, '0, 1'b0, '0, 1'b1, 32'd9, 1'b0);
    in_valid_i = 1'b1; in_data_i = 32'h06000001; req_valid_i = 1'b1; req_data_i = 32'h05000000;
    #2 rst_ni = 1'b0;
    in_valid_i = 1'b0; req_valid_i = 1'b0;
    model_reset();
    @(posedge clk_i); #1;
    tests++;
    if (rsp_valid_o !== 1'b0 || rep_valid_o !== 1'b0 || rep_pending_o !== '0 || rep_dropped_o !== '0) begin
      fails++; $display("FAIL case5_rst_out: rsp_valid=%b rep_valid=%b pending=%0d dropped=%0d required 0", rsp_valid_o, rep_valid_o, rep_pending_o, rep_dropped_o);
    end
    tests++;
    if (rep_count_o !== '0 || rep_lat_sum_o !== '0 || rep_lat_max_o !== '0 || rep_lat_min_o !== '1) begin
      fails++; $display("FAIL case5_rst_stats: count=%0d sum=%0d max=%0d min=%h required 0/0/0/ffffffff", rep_count_o, rep_lat_sum_o, rep_lat_max_o, rep_lat_min_o);
    end
    rst_ni = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    tests++;
    if (got_q.size() != 0) begin
      fails++; $display("FAIL case5_no_strobe: got %0d responses required 0", got_q.size());
    end
    send(32'h07000077, 32'd77);
    tests++;
    if (dut.tbl_q[0].valid !== 1'b1 || dut.tbl_q[0].data !== 32'h07000077) begin
      fails++; $display("FAIL case5_entry0: valid=%b data=%h required 1/07000077", dut.tbl_q[0].valid, dut.tbl_q[0].data);
    end
    report();
    tests++;
    if (rep_pending_o !== 5'(m_pending()) || rep_dropped_o !== 16'd0 || rep_count_o !== 32'd0) begin
      fails++; $display("FAIL case5_after: pending=%0d dropped=%0d count=%0d required %0d/0/0", rep_pending_o, rep_dropped_o, rep_count_o, m_pending());
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    test_reset();
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    test_send_lookup();
    test_stats();
    test_miss();
    test_broadcast();
    test_back_to_back();
    test_full_and_reset();
    tests++;
    if (exp_q.size() != 0 || got_q.size() != 0) begin
      fails++; $display("FAIL leftover_rsp: expected %0d observed %0d required 0/0", exp_q.size(), got_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
